alu_pipe_mc: RTL
================

// Module: alu_pipe_mc
// PURPOSE
//  Parametrised, handshaked ALU for the next-generation datapath: registered single-cycle ops plus an
//  iterative unsigned multiplier. Sits between decode/issue and writeback; valid/ready on both sides
//  lets the core stall on multi-cycle ops. Replaces X-default behaviour: all 8 opcodes are defined.
// PARAMETERS
//  WIDTH     32  operand/result width; power of 2, >= 8
//  MUL_STEP  4   multiplier bits retired per cycle; divides WIDTH; mul latency = WIDTH/MUL_STEP
// PORTS
//  clk          in   1      single clock, all state on rising edge
//  rst          in   1      synchronous, active-high reset
//  in_valid     in   1      operands/op presented
//  in_ready     out  1      block accepts request this cycle
//  a, b         in   WIDTH  operands
//  alu_control  in   3      opcode (see BEHAVIOUR)
//  out_valid    out  1      result registers hold a result
//  out_ready    in   1      consumer takes result this cycle
//  alu_out      out  WIDTH  result (mul: low half)
//  alu_out_hi   out  WIDTH  mul high half; 0 for all other ops
//  zout         out  1      alu_out == 0
//  ovf          out  1      signed overflow (add/sub only, else 0)
// BEHAVIOUR
//  Opcodes: 000 slt (signed a<b -> 1 else 0); 001 sll; 010 srl (logical); 011 nor; 100 sub (a-b);
//   101 or; 110 add; 111 mul (unsigned, 2*WIDTH product).
//  Shifts: amount = full b; b >= WIDTH -> result 0. Add/sub wrap modulo 2^WIDTH.
//  ovf: add = a,b same sign and result sign differs; sub = a,b differ in sign and result sign != a sign.
//  Accept: in_valid && in_ready on a rising edge. in_ready = (state==IDLE) && (!out_valid || out_ready).
//  FSM: IDLE -> (accept, op!=111) IDLE, result registered, out_valid=1 after same edge (latency 1).
//       IDLE -> (accept, op==111) MUL; operands latched, product/counter cleared.
//       MUL: each edge adds MUL_STEP partial products, counter++; on edge WIDTH/MUL_STEP after accept,
//            write {alu_out_hi,alu_out}, zout/ovf, out_valid=1, -> IDLE.
//  Output hold: while out_valid && !out_ready, alu_out/alu_out_hi/zout/ovf stable; in_ready=0.
//  Simultaneous out_ready && in_valid in IDLE: old result retired and new request accepted same edge
//   (back-to-back throughput 1/cycle for single-cycle ops). out_valid clears only on out_ready with
//   no new single-cycle completion that edge.
//  Inputs a/b/alu_control ignored outside accept edge; changing them during MUL has no effect.
//  in_valid while in MUL: ignored (in_ready=0), no state change.
//  rst (any state, incl. mid-MUL): state=IDLE, out_valid=0, alu_out=0, alu_out_hi=0, zout=1, ovf=0,
//   counter=0; in-flight op discarded, in_ready=1 on the cycle after rst deasserts.
//  zout computed on the registered alu_out only (alu_out_hi ignored).
// STRUCTURE
//  Shared package alu_pkg: opcode localparams (ALU_SLT..ALU_MUL), FSM state encoding (IDLE, MUL).
//  Sub-module alu_mul_iter: WIDTH/MUL_STEP shift-add engine; ports clk, rst, start, a, b -> busy,
//   done (1-cycle pulse), prod[2*WIDTH-1:0]. Top holds FSM, single-cycle ops, flags, output regs.
// TESTING (WIDTH=32, MUL_STEP=4)
//  add a=0x7FFFFFFF b=1 -> alu_out=0x80000000, ovf=1, zout=0, out_valid one edge after accept.
//  sub a=5 b=5 -> alu_out=0, zout=1, ovf=0; slt a=0xFFFFFFFF b=1 -> alu_out=1.
//  sll a=1 b=31 -> 0x80000000; sll a=1 b=32 -> 0; srl a=0x80000000 b=31 -> 1.
//  mul a=0x00010000 b=0x00010003 -> alu_out=0x00030000, alu_out_hi=1, out_valid 8 edges after accept;
//   in_ready=0 throughout.
//  Backpressure: out_ready=0 for 5 cycles after add -> outputs stable, in_ready=0; out_ready=1 with
//   in_valid=1 (or a=3 b=4) -> new result 7 next cycle, no bubble.
//  rst asserted 3 edges into mul -> out_valid=0, zout=1, alu_out=0; following add 2+2 returns 4 normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode and FSM encodings for the handshaked ALU and its multiplier engine.
package alu_pkg;

   localparam logic [2:0] ALU_SLT = 3'b000;
   localparam logic [2:0] ALU_SLL = 3'b001;
   localparam logic [2:0] ALU_SRL = 3'b010;
   localparam logic [2:0] ALU_NOR = 3'b011;
   localparam logic [2:0] ALU_SUB = 3'b100;
   localparam logic [2:0] ALU_OR  = 3'b101;
   localparam logic [2:0] ALU_ADD = 3'b110;
   localparam logic [2:0] ALU_MUL = 3'b111;

   typedef enum logic {
      IDLE = 1'b0,
      MUL  = 1'b1
   } state_e;

   function automatic logic add_ovf(input logic a_s, input logic b_s, input logic r_s);
      return (a_s == b_s) && (r_s != a_s);
   endfunction

   function automatic logic sub_ovf(input logic a_s, input logic b_s, input logic r_s);
      return (a_s != b_s) && (r_s != a_s);
   endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier retiring MUL_STEP multiplier bits per clock.
// done and prod are valid together in the cycle before the final edge, so the owner can
// register the product on the same edge the engine retires its last partial products.
module alu_mul_iter
   import alu_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int MUL_STEP = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] prod
);

   localparam int N_STEPS = WIDTH / MUL_STEP;
   localparam int CNT_W   = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;

   logic               busy_q, busy_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] partial;
   logic [2*WIDTH-1:0] acc_nxt;
   logic               last;

   always_comb begin
      partial = '0;
      for (int i = 0; i < MUL_STEP; i++) begin
         if (mplier_q[i]) partial = partial + (mcand_q << i);
      end
      acc_nxt = acc_q + partial;
      last    = busy_q && (cnt_q == CNT_W'(N_STEPS - 1));
   end

   always_comb begin
      busy_d   = busy_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      if (start) begin
         busy_d   = 1'b1;
         cnt_d    = '0;
         mcand_d  = {{WIDTH{1'b0}}, a};
         mplier_d = b;
         acc_d    = '0;
      end else if (busy_q) begin
         acc_d    = acc_nxt;
         mcand_d  = mcand_q << MUL_STEP;
         mplier_d = mplier_q >> MUL_STEP;
         cnt_d    = cnt_q + 1'b1;
         if (last) begin
            busy_d = 1'b0;
            cnt_d  = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q   <= 1'b0;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
      end else begin
         busy_q   <= busy_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
      end
   end

   assign busy = busy_q;
   assign done = last;
   assign prod = acc_nxt;

endmodule

// File: rtl/alu_pipe_mc.sv
// Handshaked ALU: registered single-cycle ops plus an iterative unsigned multiply.
//   state | meaning
//   IDLE  | accepting requests when the output slot is free or being retired
//   MUL   | multiplier engine running; requests held off until the product lands
module alu_pipe_mc
   import alu_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int MUL_STEP = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       alu_control,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] alu_out,
   output logic [WIDTH-1:0] alu_out_hi,
   output logic             zout,
   output logic             ovf
);

   localparam int SH_W = $clog2(WIDTH);

   state_e           state_q, state_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] alu_out_q, alu_out_d;
   logic [WIDTH-1:0] alu_out_hi_q, alu_out_hi_d;
   logic             zout_q, zout_d;
   logic             ovf_q, ovf_d;

   logic               accept;
   logic               mul_start;
   logic               mul_busy;
   logic               mul_done;
   logic [2*WIDTH-1:0] mul_prod;

   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic             shift_oor;
   logic [WIDTH-1:0] sc_res;
   logic             sc_ovf;

   // mul_busy is always low in IDLE; it only guards against engine/FSM skew.
   assign in_ready  = (state_q == IDLE) && !mul_busy && (!out_valid_q || out_ready);
   assign accept    = in_valid && in_ready;
   assign mul_start = accept && (alu_control == ALU_MUL);

   alu_mul_iter #(
      .WIDTH    (WIDTH),
      .MUL_STEP (MUL_STEP)
   ) u_mul (
      .clk   (clk),
      .rst   (rst),
      .start (mul_start),
      .a     (a),
      .b     (b),
      .busy  (mul_busy),
      .done  (mul_done),
      .prod  (mul_prod)
   );

   always_comb begin
      sum       = a + b;
      diff      = a - b;
      shift_oor = (b >= WIDTH'(WIDTH));
      sc_res    = '0;
      sc_ovf    = 1'b0;
      case (alu_control)
         ALU_SLT: sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_SLL: sc_res = shift_oor ? '0 : (a << b[SH_W-1:0]);
         ALU_SRL: sc_res = shift_oor ? '0 : (a >> b[SH_W-1:0]);
         ALU_NOR: sc_res = ~(a | b);
         ALU_SUB: begin
            sc_res = diff;
            sc_ovf = sub_ovf(a[WIDTH-1], b[WIDTH-1], diff[WIDTH-1]);
         end
         ALU_OR:  sc_res = a | b;
         ALU_ADD: begin
            sc_res = sum;
            sc_ovf = add_ovf(a[WIDTH-1], b[WIDTH-1], sum[WIDTH-1]);
         end
         ALU_MUL: sc_res = '0;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      out_valid_d  = out_valid_q && !out_ready;
      alu_out_d    = alu_out_q;
      alu_out_hi_d = alu_out_hi_q;
      zout_d       = zout_q;
      ovf_d        = ovf_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (alu_control == ALU_MUL) begin
                  state_d = MUL;
               end else begin
                  alu_out_d    = sc_res;
                  alu_out_hi_d = '0;
                  zout_d       = (sc_res == '0);
                  ovf_d        = sc_ovf;
                  out_valid_d  = 1'b1;
               end
            end
         end
         MUL: begin
            if (mul_done) begin
               alu_out_d    = mul_prod[WIDTH-1:0];
               alu_out_hi_d = mul_prod[2*WIDTH-1:WIDTH];
               zout_d       = (mul_prod[WIDTH-1:0] == '0);
               ovf_d        = 1'b0;
               out_valid_d  = 1'b1;
               state_d      = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         out_valid_q  <= 1'b0;
         alu_out_q    <= '0;
         alu_out_hi_q <= '0;
         zout_q       <= 1'b1;
         ovf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         out_valid_q  <= out_valid_d;
         alu_out_q    <= alu_out_d;
         alu_out_hi_q <= alu_out_hi_d;
         zout_q       <= zout_d;
         ovf_q        <= ovf_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign alu_out    = alu_out_q;
   assign alu_out_hi = alu_out_hi_q;
   assign zout       = zout_q;
   assign ovf        = ovf_q;

endmodule
